// File: rtl/axis_rx_sink.sv
// AXI4-Stream receive endpoint: FWFT beat buffer with a local read port,
// packet/byte statistics and sticky protocol-violation flags.
module axis_rx_sink #(
  parameter int  DATA_W = 32,
  parameter int  ID_W   = 4,
  parameter int  DEST_W = 4,
  parameter int  USER_W = 1,
  parameter int  DEPTH  = 8,
  localparam int KEEP_W = DATA_W / 8,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              TVALID,
  output logic              TREADY,
  input  logic [DATA_W-1:0] TDATA,
  input  logic [KEEP_W-1:0] TSTRB,
  input  logic [KEEP_W-1:0] TKEEP,
  input  logic              TLAST,
  input  logic [ID_W-1:0]   TID,
  input  logic [DEST_W-1:0] TDEST,
  input  logic [USER_W-1:0] TUSER,
  input  logic              rx_pause,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [KEEP_W-1:0] rd_strb,
  output logic [KEEP_W-1:0] rd_keep,
  output logic              rd_last,
  output logic [ID_W-1:0]   rd_id,
  output logic [DEST_W-1:0] rd_dest,
  output logic [USER_W-1:0] rd_user,
  output logic [CNT_W-1:0]  fill_level,
  output logic              in_pkt,
  output logic [31:0]       pkt_cnt,
  output logic [31:0]       byte_cnt,
  input  logic              clr_stats,
  output logic [3:0]        err,
  input  logic              clr_err
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = 1 + USER_W + DEST_W + ID_W + 2 * KEEP_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

  typedef enum logic {ST_IDLE = 1'b0, ST_PKT = 1'b1} state_t;

  logic [1:0]         rst_sync_q;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  state_t             state_q, state_d;
  logic [ID_W-1:0]    cap_id_q, cap_id_d;
  logic [DEST_W-1:0]  cap_dest_q, cap_dest_d;
  logic [31:0]        pkt_cnt_q, pkt_cnt_d, byte_cnt_q, byte_cnt_d;
  logic [3:0]         err_q, err_d, err_set;
  logic               stall_q;
  logic [ENTRY_W-1:0] hold_q;
  logic [ENTRY_W-1:0] in_entry, head_entry;
  logic               push, pop;

  function automatic logic [31:0] popcount(input logic [KEEP_W-1:0] k);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < KEEP_W; i++) n = n + 32'(k[i]);
    return n;
  endfunction

  // Both sides are valid/ready: a transfer happens on a rising edge where valid
  // and ready are both high. TREADY never looks at TVALID, and a full buffer
  // refuses a beat even when the head is popped in the same cycle.
  assign TREADY = rst_sync_q[1] && (count_q < FULL_LVL) && !rx_pause;
  assign push   = TVALID && TREADY;
  assign rd_valid = (count_q != '0);
  assign pop    = rd_valid && rd_ready;

  assign in_entry   = {TLAST, TUSER, TDEST, TID, TKEEP, TSTRB, TDATA};
  assign head_entry = mem_q[rd_ptr_q];
  assign {rd_last, rd_user, rd_dest, rd_id, rd_keep, rd_strb, rd_data} = head_entry;

  assign fill_level = count_q;
  assign in_pkt     = (state_q == ST_PKT);
  assign pkt_cnt    = pkt_cnt_q;
  assign byte_cnt   = byte_cnt_q;
  assign err        = err_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cap_id_d   = cap_id_q;
    cap_dest_d = cap_dest_q;
    case (state_q)
      ST_IDLE: begin
        if (push && !TLAST) begin
          state_d    = ST_PKT;
          cap_id_d   = TID;
          cap_dest_d = TDEST;
        end
      end
      ST_PKT: begin
        if (push && TLAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pkt_cnt_d  = clr_stats ? 32'd0 : pkt_cnt_q;
    byte_cnt_d = clr_stats ? 32'd0 : byte_cnt_q;
    if (push) begin
      pkt_cnt_d  = pkt_cnt_d + 32'(TLAST);
      byte_cnt_d = byte_cnt_d + popcount(TKEEP);
    end
  end

  // stall_q/hold_q remember a refused offer so the next edge can check that
  // the source kept TVALID high and the payload stable.
  always_comb begin
    err_set    = '0;
    err_set[0] = stall_q && !TVALID;
    err_set[1] = stall_q && TVALID && (in_entry != hold_q);
    err_set[2] = push && (state_q == ST_PKT) && ((TID != cap_id_q) || (TDEST != cap_dest_q));
    err_set[3] = push && |(TSTRB & ~TKEEP);
    err_d      = (clr_err ? 4'b0 : err_q) | err_set;
  end

  always_ff @(posedge ACLK) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rst_sync_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      cap_id_q   <= '0;
      cap_dest_q <= '0;
      pkt_cnt_q  <= '0;
      byte_cnt_q <= '0;
      err_q      <= '0;
      stall_q    <= 1'b0;
      hold_q     <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      cap_id_q   <= cap_id_d;
      cap_dest_q <= cap_dest_d;
      pkt_cnt_q  <= pkt_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      err_q      <= err_d;
      stall_q    <= TVALID && !TREADY;
      hold_q     <= in_entry;
    end
  end

endmodule

// File: tb/tb_axis_rx_sink.sv
// Bench for axis_rx_sink: directed table, corner-case sequences and random
// traffic, all checked against a queue-based model of the receiver.
module tb_axis_rx_sink;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
    logic [3:0]  id;
    logic [3:0]  dest;
    logic        user;
  } beat_t;

  typedef struct {
    logic        tvalid;
    logic        tlast;
    logic [3:0]  tkeep;
    logic [31:0] tdata;
    logic        exp_in_pkt;
    logic        exp_rd_valid;
    logic [3:0]  exp_fill;
    logic [31:0] exp_rd_data;
  } vec_t;

  logic ACLK, ARESETn, TVALID, TREADY, TLAST, rx_pause;
  logic [31:0] TDATA;
  logic [3:0]  TSTRB, TKEEP, TID, TDEST;
  logic [0:0]  TUSER;
  logic rd_valid, rd_ready, rd_last, in_pkt, clr_stats, clr_err;
  logic [31:0] rd_data, pkt_cnt, byte_cnt;
  logic [3:0]  rd_strb, rd_keep, rd_id, rd_dest, err;
  logic [0:0]  rd_user;
  logic [CNT_W-1:0] fill_level;
  logic [49:0] rd_bus;

  int n_vec = 0;
  int n_miss = 0;

  // reference model state
  beat_t q_m[$];
  int    rel_cnt;
  logic  in_pkt_m, stall_m, acc_m;
  logic [3:0] cap_id_m, cap_dest_m, err_m;
  logic [31:0] pkt_m, byte_m;
  beat_t prev_m;
  logic pause_tog, pause_rand, rdy_rand;

  axis_rx_sink dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .TVALID(TVALID), .TREADY(TREADY),
    .TDATA(TDATA), .TSTRB(TSTRB), .TKEEP(TKEEP), .TLAST(TLAST),
    .TID(TID), .TDEST(TDEST), .TUSER(TUSER), .rx_pause(rx_pause),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_strb(rd_strb), .rd_keep(rd_keep), .rd_last(rd_last), .rd_id(rd_id),
    .rd_dest(rd_dest), .rd_user(rd_user), .fill_level(fill_level),
    .in_pkt(in_pkt), .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt),
    .clr_stats(clr_stats), .err(err), .clr_err(clr_err)
  );

  assign rd_bus = {rd_data, rd_strb, rd_keep, rd_last, rd_id, rd_dest, rd_user};

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %0h required %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic exp_tready();
    return ARESETn && (rel_cnt >= 2) && (q_m.size() < DEPTH) && !rx_pause;
  endfunction

  function automatic beat_t cur_beat();
    beat_t b;
    b.data = TDATA; b.strb = TSTRB; b.keep = TKEEP; b.last = TLAST;
    b.id = TID; b.dest = TDEST; b.user = TUSER[0];
    return b;
  endfunction

  task automatic model_reset();
    q_m.delete();
    rel_cnt = 0; in_pkt_m = 0; stall_m = 0; acc_m = 0;
    cap_id_m = 0; cap_dest_m = 0; err_m = 0; pkt_m = 0; byte_m = 0; prev_m = '0;
  endtask

  task automatic model_update();
    beat_t cur;
    logic et, acc, pop;
    logic [3:0] s;
    if (!ARESETn) begin
      model_reset();
      return;
    end
    cur = cur_beat();
    et  = exp_tready();
    acc = TVALID && et;
    pop = (q_m.size() != 0) && rd_ready;
    s[0] = stall_m && !TVALID;
    s[1] = stall_m && TVALID && (cur != prev_m);
    s[2] = acc && in_pkt_m && ((cur.id != cap_id_m) || (cur.dest != cap_dest_m));
    s[3] = acc && ((cur.strb & ~cur.keep) != 4'b0);
    err_m   = (clr_err ? 4'b0 : err_m) | s;
    stall_m = TVALID && !et;
    prev_m  = cur;
    if (pop) void'(q_m.pop_front());
    if (acc) q_m.push_back(cur);
    if (clr_stats) begin
      pkt_m  = (acc && cur.last) ? 32'd1 : 32'd0;
      byte_m = acc ? 32'($countones(cur.keep)) : 32'd0;
    end else if (acc) begin
      pkt_m  = pkt_m + 32'(cur.last);
      byte_m = byte_m + 32'($countones(cur.keep));
    end
    if (acc) begin
      if (in_pkt_m && cur.last) in_pkt_m = 0;
      else if (!in_pkt_m && !cur.last) begin
        in_pkt_m = 1; cap_id_m = cur.id; cap_dest_m = cur.dest;
      end
    end
    acc_m = acc;
    if (rel_cnt < 2) rel_cnt++;
  endtask

  // One clock: settle, compare every output with the model, advance both.
  task automatic step();
    if (pause_tog) rx_pause = !rx_pause;
    else if (pause_rand) rx_pause = ($urandom_range(0, 3) == 0);
    if (rdy_rand) rd_ready = ($urandom_range(0, 1) == 1);
    #1;
    check("tready", 64'(TREADY), 64'(exp_tready()));
    check("rd_valid", 64'(rd_valid), 64'(q_m.size() != 0));
    check("fill_level", 64'(fill_level), 64'(q_m.size()));
    check("in_pkt", 64'(in_pkt), 64'(in_pkt_m));
    check("pkt_cnt", 64'(pkt_cnt), 64'(pkt_m));
    check("byte_cnt", 64'(byte_cnt), 64'(byte_m));
    check("err", 64'(err), 64'(err_m));
    if (q_m.size() != 0) check("rd_head", 64'(rd_bus), 64'(q_m[0]));
    @(posedge ACLK);
    model_update();
    @(negedge ACLK);
  endtask

  task automatic drive(input beat_t b);
    TDATA = b.data; TSTRB = b.strb; TKEEP = b.keep; TLAST = b.last;
    TID = b.id; TDEST = b.dest; TUSER[0] = b.user;
  endtask

  function automatic beat_t mk(input logic [31:0] d, input logic [3:0] k,
                               input logic l, input logic [3:0] id);
    beat_t b;
    b.data = d; b.strb = k; b.keep = k; b.last = l; b.id = id; b.dest = 4'd2; b.user = 1'b0;
    return b;
  endfunction

  task automatic offer(input beat_t b);
    int n;
    drive(b);
    TVALID = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!acc_m && n < 200);
    if (!acc_m) check("offer_timeout", 64'd1, 64'd0);
    TVALID = 1'b0;
  endtask

  task automatic idle(input int n);
    TVALID = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    b.data = $urandom;
    b.keep = 4'($urandom_range(1, 15));
    b.strb = ($urandom_range(0, 9) == 0) ? 4'($urandom) : b.keep;
    b.last = ($urandom_range(0, 3) == 0);
    b.id   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd5;
    b.dest = 4'd6;
    b.user = 1'($urandom);
    return b;
  endfunction

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 4'hF, 32'hA000_0000, 1'b0, 1'b0, 4'd0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 4'hF, 32'hA000_0001, 1'b1, 1'b1, 4'd1, 32'hA000_0000};
    tbl[2] = '{1'b1, 1'b0, 4'hF, 32'hA000_0002, 1'b1, 1'b1, 4'd1, 32'hA000_0001};
    tbl[3] = '{1'b1, 1'b1, 4'h3, 32'hA000_0003, 1'b1, 1'b1, 4'd1, 32'hA000_0002};
    tbl[4] = '{1'b0, 1'b0, 4'h0, 32'h0,         1'b0, 1'b1, 4'd1, 32'hA000_0003};
    tbl[5] = '{1'b0, 1'b0, 4'h0, 32'h0,         1'b0, 1'b0, 4'd0, 32'h0};

    pause_tog = 0; pause_rand = 0; rdy_rand = 0;
    TVALID = 0; TDATA = 0; TSTRB = 0; TKEEP = 0; TLAST = 0; TID = 0; TDEST = 0; TUSER = 0;
    rx_pause = 0; rd_ready = 0; clr_stats = 0; clr_err = 0;
    model_reset();
    ARESETn = 1'b1;
    #1 ARESETn = 1'b0;
    #2;
    check("rst_tready", 64'(TREADY), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_fill", 64'(fill_level), 64'd0);
    check("rst_in_pkt", 64'(in_pkt), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("rst_byte_cnt", 64'(byte_cnt), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(negedge ACLK);
    step();
    ARESETn = 1'b1;
    rd_ready = 1'b1;
    idle(3);

    // 1: four-beat packet through the table
    for (int i = 0; i < 6; i++) begin
      TVALID = tbl[i].tvalid; TLAST = tbl[i].tlast; TKEEP = tbl[i].tkeep;
      TSTRB = tbl[i].tkeep; TDATA = tbl[i].tdata; TID = 4'd1; TDEST = 4'd2;
      #1;
      check($sformatf("t1_in_pkt[%0d]", i), 64'(in_pkt), 64'(tbl[i].exp_in_pkt));
      check($sformatf("t1_rd_valid[%0d]", i), 64'(rd_valid), 64'(tbl[i].exp_rd_valid));
      check($sformatf("t1_fill[%0d]", i), 64'(fill_level), 64'(tbl[i].exp_fill));
      if (tbl[i].exp_rd_valid)
        check($sformatf("t1_rd_data[%0d]", i), 64'(rd_data), 64'(tbl[i].exp_rd_data));
      step();
    end
    check("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);
    check("t1_byte_cnt", 64'(byte_cnt), 64'd14);
    check("t1_err", 64'(err), 64'd0);

    // 2: fill to DEPTH with the reader stalled, then one pop admits one beat
    rd_ready = 1'b0;
    for (int k = 0; k < 8; k++) offer(mk(32'hB000_0000 + 32'(k), 4'hF, 1'b0, 4'd3));
    drive(mk(32'hB000_0008, 4'hF, 1'b0, 4'd3));
    TVALID = 1'b1;
    step(); step();
    check("t2_full_fill", 64'(fill_level), 64'd8);
    check("t2_full_tready", 64'(TREADY), 64'd0);
    rd_ready = 1'b1;
    #1 check("t2_pop_tready", 64'(TREADY), 64'd0);
    step();
    rd_ready = 1'b0;
    #1 check("t2_reopen_tready", 64'(TREADY), 64'd1);
    step();
    drive(mk(32'hB000_0009, 4'hF, 1'b1, 4'd3));
    step();
    check("t2_refull_fill", 64'(fill_level), 64'd8);
    check("t2_refull_tready", 64'(TREADY), 64'd0);
    rd_ready = 1'b1;
    offer(mk(32'hB000_0009, 4'hF, 1'b1, 4'd3));
    idle(10);

    // 3: alternating backpressure over two packets
    clr_stats = 1'b1; step(); clr_stats = 1'b0;
    pause_tog = 1;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 3; k++) offer(mk(32'hC000_0000 + 32'(p * 16 + k), 4'hF, k == 2, 4'd4));
    idle(6);
    pause_tog = 0; rx_pause = 1'b0;
    check("t3_pkt_cnt", 64'(pkt_cnt), 64'd2);
    check("t3_byte_cnt", 64'(byte_cnt), 64'd24);

    // 4: stall violations
    rx_pause = 1'b1;
    drive(mk(32'hD000_0000, 4'hF, 1'b1, 4'd4));
    TVALID = 1'b1; step();
    TVALID = 1'b0; step();
    check("t4_err_drop", 64'(err), 64'h1);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    check("t4_clr", 64'(err), 64'h0);
    TVALID = 1'b1; step();
    TDATA = 32'hD000_0001; step();
    check("t4_err_change", 64'(err), 64'h2);
    rx_pause = 1'b0; step();
    TVALID = 1'b0;
    clr_err = 1'b1; step(); clr_err = 1'b0;
    check("t4_clr2", 64'(err), 64'h0);

    // 5: TID change inside a packet, then TSTRB set on a null lane
    offer(mk(32'hE000_0000, 4'hF, 1'b0, 4'd1));
    offer(mk(32'hE000_0001, 4'hF, 1'b1, 4'd2));
    idle(1);
    check("t5_err_id", 64'(err), 64'h4);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    begin
      beat_t b;
      b = mk(32'hE000_0002, 4'b1110, 1'b1, 4'd1);
      b.strb = 4'b0001;
      offer(b);
    end
    idle(1);
    check("t5_err_strb", 64'(err), 64'h8);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    idle(4);

    // random traffic, including occasional protocol violations
    pause_rand = 1; rdy_rand = 1;
    for (int c = 0; c < 400; c++) begin
      if (TVALID && !acc_m) begin
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) TVALID = 1'b0;
        else if (r == 1) drive(rand_beat());
      end else begin
        TVALID = ($urandom_range(0, 2) != 0);
        drive(rand_beat());
      end
      clr_stats = ($urandom_range(0, 30) == 0);
      clr_err   = ($urandom_range(0, 15) == 0);
      step();
    end
    pause_rand = 0; rdy_rand = 0; rx_pause = 1'b0; rd_ready = 1'b1;
    clr_stats = 1'b0; clr_err = 1'b0;
    idle(12);

    // 6: reset mid-packet with entries buffered, then counter wrap
    rd_ready = 1'b0;
    for (int k = 0; k < 3; k++) offer(mk(32'hF000_0000 + 32'(k), 4'hF, 1'b0, 4'd7));
    #2 ARESETn = 1'b0;
    #1;
    model_reset();
    check("t6_rd_valid", 64'(rd_valid), 64'd0);
    check("t6_fill", 64'(fill_level), 64'd0);
    check("t6_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("t6_byte_cnt", 64'(byte_cnt), 64'd0);
    check("t6_in_pkt", 64'(in_pkt), 64'd0);
    @(negedge ACLK);
    rd_ready = 1'b1;
    step();
    ARESETn = 1'b1;
    offer(mk(32'hF100_0000, 4'hF, 1'b0, 4'd8));
    offer(mk(32'hF100_0001, 4'hF, 1'b1, 4'd8));
    idle(3);
    check("t6_pkt_after", 64'(pkt_cnt), 64'd1);
    check("t6_byte_after", 64'(byte_cnt), 64'd8);
    dut.byte_cnt_q = 32'hFFFF_FFFE;
    byte_m = 32'hFFFF_FFFE;
    offer(mk(32'hF100_0002, 4'hF, 1'b1, 4'd8));
    idle(2);
    check("t6_byte_wrap", 64'(byte_cnt), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
